// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bundle: PC hand-off, instruction-memory req/ack and decode valid/ready.
// master = fetch unit side, slave = surrounding PC / memory / decode side.
interface inst_fetch_unit_if #(
    parameter int unsigned WORD_WIDTH = 32
);
    logic [WORD_WIDTH-1:0] pc_addr;
    logic                  pc_valid;
    logic                  pc_stall;
    logic                  flush;
    logic                  imem_req;
    logic [WORD_WIDTH-1:0] imem_addr;
    logic                  imem_ack;
    logic [WORD_WIDTH-1:0] imem_rdata;
    logic                  if_valid;
    logic [WORD_WIDTH-1:0] if_inst;
    logic [WORD_WIDTH-1:0] if_pc;
    logic                  id_ready;

    modport master (
        input  pc_addr, pc_valid, flush, imem_ack, imem_rdata, id_ready,
        output pc_stall, imem_req, imem_addr, if_valid, if_inst, if_pc
    );

    modport slave (
        output pc_addr, pc_valid, flush, imem_ack, imem_rdata, id_ready,
        input  pc_stall, imem_req, imem_addr, if_valid, if_inst, if_pc
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: one outstanding imem request, 2-entry registered output queue, flush/drain.
// Optional FETCH_PERF_EN adds saturating wait/flush performance counters.
module inst_fetch_unit #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
`ifdef FETCH_PERF_EN
    output logic [31:0]       perf_wait_cnt,
    output logic [31:0]       perf_flush_cnt,
`endif
    inst_fetch_unit_if.master io_fetch
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_req;
    logic [WORD_WIDTH-1:0] r_addr;
    logic [1:0]            r_count;
    logic                  r_valid;
    logic [WORD_WIDTH-1:0] r_head_inst;
    logic [WORD_WIDTH-1:0] r_head_pc;
    logic [WORD_WIDTH-1:0] r_tail_inst;
    logic [WORD_WIDTH-1:0] r_tail_pc;

    logic       w_pop;
    logic       w_ack;
    logic       w_push;
    logic       w_stall;
    logic       w_accept;
    logic [1:0] w_cnt_after_pop;

    assign w_pop           = r_valid & io_fetch.id_ready;
    assign w_ack           = r_req & io_fetch.imem_ack;
    assign w_push          = (r_state == ST_REQ) & w_ack & ~io_fetch.flush;
    assign w_cnt_after_pop = w_pop ? (r_count - 2'd1) : r_count;
    assign w_stall         = ~(rst & (r_state == ST_IDLE) & ~io_fetch.flush
                               & (w_cnt_after_pop < 2'(FIFO_DEPTH)));
    assign w_accept        = io_fetch.pc_valid & ~w_stall;

    assign io_fetch.pc_stall  = w_stall;
    assign io_fetch.imem_req  = r_req;
    assign io_fetch.imem_addr = r_addr;
    assign io_fetch.if_valid  = r_valid;
    assign io_fetch.if_inst   = r_head_inst;
    assign io_fetch.if_pc     = r_head_pc;

    // Request FSM; an ack in a flush cycle retires the request without pushing
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= io_fetch.pc_addr;
                        r_req   <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_ack) begin
                        r_req   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (io_fetch.flush) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_ack) begin
                        r_req   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output queue: head lives directly in the output registers, tail behind it
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count     <= 2'd0;
            r_valid     <= 1'b0;
            r_head_inst <= '0;
            r_head_pc   <= '0;
            r_tail_inst <= '0;
            r_tail_pc   <= '0;
        end else if (io_fetch.flush) begin
            r_count <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head_inst <= io_fetch.imem_rdata;
                        r_head_pc   <= r_addr;
                    end else begin
                        r_tail_inst <= io_fetch.imem_rdata;
                        r_tail_pc   <= r_addr;
                    end
                    r_count <= r_count + 2'd1;
                    r_valid <= 1'b1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_head_inst <= r_tail_inst;
                        r_head_pc   <= r_tail_pc;
                    end
                    r_count <= r_count - 2'd1;
                    r_valid <= (r_count == 2'd2);
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_head_inst <= r_tail_inst;
                        r_head_pc   <= r_tail_pc;
                        r_tail_inst <= io_fetch.imem_rdata;
                        r_tail_pc   <= r_addr;
                    end else begin
                        r_head_inst <= io_fetch.imem_rdata;
                        r_head_pc   <= r_addr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_wait_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_wait_evt;
    logic        w_flush_evt;

    assign w_wait_evt     = r_req & ~io_fetch.imem_ack;
    assign w_flush_evt    = io_fetch.flush & (r_valid | r_req);
    assign perf_wait_cnt  = r_wait_cnt;
    assign perf_flush_cnt = r_flush_cnt;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wait_cnt  <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (w_wait_evt && (r_wait_cnt != 32'hFFFF_FFFF)) begin
                r_wait_cnt <= r_wait_cnt + 32'd1;
            end
            if (w_flush_evt && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios then random traffic against a transaction-level model.
module tb_inst_fetch_unit;
    logic clk;
    logic rst;

    inst_fetch_unit_if #(.WORD_WIDTH(32)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_wait_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    inst_fetch_unit #(.WORD_WIDTH(32), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef FETCH_PERF_EN
        .perf_wait_cnt  (perf_wait_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .io_fetch       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: outstanding-request flags plus a queue of delivered {pc, inst}
    bit          m_busy;
    bit          m_drain;
    bit          m_just_reset;
    logic [31:0] m_addr;
    logic [31:0] m_q_pc[$];
    logic [31:0] m_q_inst[$];
    logic [31:0] m_wait;
    logic [31:0] m_flc;

    // Stimulus state
    logic [31:0] pc;
    logic [31:0] popped[$];
    bit          acc;
    int          age;
    int          g_delay;
    bit          g_ready;
    bit          g_rand;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check pc_stall, advance model across the edge, check registered outputs
    task automatic tick(input string tag);
        bit pop;
        bit stall_x;
        bit ack_x;
        int sz;
        #1;
        sz      = m_q_pc.size();
        pop     = (sz != 0) && bus.id_ready;
        stall_x = !(rst && !m_busy && !bus.flush && ((sz - (pop ? 1 : 0)) < 2));
        chk({tag, " pc_stall"}, 32'(bus.pc_stall), 32'(stall_x));
        acc   = rst && bus.pc_valid && !stall_x;
        ack_x = m_busy && bus.imem_ack;
        if (rst && bus.if_valid && bus.id_ready) popped.push_back(bus.if_pc);
        if (!rst) begin
            m_busy = 1'b0; m_drain = 1'b0; m_addr = 32'd0; m_just_reset = 1'b1;
            m_q_pc.delete(); m_q_inst.delete();
            m_wait = 32'd0; m_flc = 32'd0;
        end else begin
            m_just_reset = 1'b0;
            if (m_busy && !bus.imem_ack && m_wait != 32'hFFFF_FFFF) m_wait = m_wait + 32'd1;
            if (bus.flush && (sz != 0 || m_busy) && m_flc != 32'hFFFF_FFFF) m_flc = m_flc + 32'd1;
            if (bus.flush) begin
                m_q_pc.delete(); m_q_inst.delete();
                if (m_busy) begin
                    if (ack_x) begin m_busy = 1'b0; m_drain = 1'b0; end
                    else m_drain = 1'b1;
                end
            end else begin
                if (pop) begin void'(m_q_pc.pop_front()); void'(m_q_inst.pop_front()); end
                if (ack_x) begin
                    if (!m_drain) begin m_q_pc.push_back(m_addr); m_q_inst.push_back(bus.imem_rdata); end
                    m_busy = 1'b0; m_drain = 1'b0;
                end else if (acc) begin
                    m_busy = 1'b1; m_addr = bus.pc_addr;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, " imem_req"}, 32'(bus.imem_req), 32'(m_busy));
        if (m_busy || m_just_reset) chk({tag, " imem_addr"}, bus.imem_addr, m_addr);
        chk({tag, " if_valid"}, 32'(bus.if_valid), 32'(m_q_pc.size() != 0));
        if (m_q_pc.size() != 0) begin
            chk({tag, " if_inst"}, bus.if_inst, m_q_inst[0]);
            chk({tag, " if_pc"}, bus.if_pc, m_q_pc[0]);
        end else if (m_just_reset) begin
            chk({tag, " if_inst rst"}, bus.if_inst, 32'd0);
            chk({tag, " if_pc rst"}, bus.if_pc, 32'd0);
        end
`ifdef FETCH_PERF_EN
        chk({tag, " perf_wait"}, perf_wait_cnt, m_wait);
        chk({tag, " perf_flush"}, perf_flush_cnt, m_flc);
`endif
    endtask

    // Drive one cycle of PC/memory/decode behaviour according to the current mode
    task automatic cyc(input string tag);
        if (g_rand) begin
            rst            = ($urandom_range(63) != 0);
            bus.flush      = ($urandom_range(11) == 0);
            bus.pc_valid   = ($urandom_range(3) != 0);
            bus.pc_addr    = $urandom;
            bus.imem_ack   = ($urandom_range(9) < 4);
            bus.imem_rdata = $urandom;
            bus.id_ready   = ($urandom_range(9) < 6);
        end else begin
            age            = bus.imem_req ? age + 1 : 0;
            bus.flush      = 1'b0;
            bus.pc_valid   = 1'b1;
            bus.pc_addr    = pc;
            bus.id_ready   = g_ready;
            bus.imem_ack   = bus.imem_req && (age > g_delay);
            bus.imem_rdata = bus.imem_ack ? (bus.imem_addr ^ 32'hA5A5_5A5A) : 32'd0;
        end
        tick(tag);
        if (acc && !g_rand) pc = pc + 32'd4;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        bus.flush = 1'b0; bus.pc_valid = 1'b0; bus.imem_ack = 1'b0; bus.id_ready = 1'b0;
        tick(tag);
        rst = 1'b1;
        pc = 32'd0; age = 0; popped.delete();
    endtask

    task automatic run_pops(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && popped.size() < n; i++) cyc(tag);
        chk({tag, " pop count"}, 32'(popped.size()), 32'(n));
    endtask

    task automatic run_until_req(input int budget, input string tag);
        for (int i = 0; i < budget && !bus.imem_req; i++) cyc(tag);
        chk({tag, " req seen"}, 32'(bus.imem_req), 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        bus.pc_addr = 32'd0; bus.pc_valid = 1'b0; bus.flush = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0; bus.id_ready = 1'b0;
        g_rand = 1'b0; g_delay = 0; g_ready = 1'b1; age = 0; pc = 32'd0;

        // Reset state
        do_reset("reset");
        do_reset("reset2");

        // Zero-wait fetch
        g_ready = 1'b1; g_delay = 0;
        run_pops(3, 30, "zw");
        if (popped.size() >= 3) begin
            chk("zw pc0", popped[0], 32'h0);
            chk("zw pc1", popped[1], 32'h4);
            chk("zw pc2", popped[2], 32'h8);
        end

        // Back-pressure: queue fills with 0x0/0x4 while 0x8 waits
        do_reset("bp rst");
        g_ready = 1'b0; g_delay = 0;
        for (int i = 0; i < 12; i++) cyc("bp hold");
        chk("bp head pc", bus.if_pc, 32'h0);
        chk("bp stall", 32'(bus.pc_stall), 32'd1);
        g_ready = 1'b1;
        run_pops(3, 30, "bp drain");
        if (popped.size() >= 3) begin
            chk("bp pc0", popped[0], 32'h0);
            chk("bp pc1", popped[1], 32'h4);
            chk("bp pc2", popped[2], 32'h8);
        end

        // Slow memory: three wait cycles per request
        do_reset("slow rst");
        g_delay = 3;
        run_pops(2, 40, "slow");
`ifdef FETCH_PERF_EN
        do_reset("slow perf rst");
        run_pops(1, 20, "slow perf");
        chk("slow perf_wait=3", perf_wait_cnt, 32'd3);
`endif

        // Flush while a request to 0x10 is outstanding; late data 0xDEAD is dropped
        do_reset("fr rst");
        pc = 32'h10; g_delay = 1000; g_ready = 1'b1;
        run_until_req(5, "fr wait");
        bus.flush = 1'b1; bus.imem_ack = 1'b0;
        tick("fr flush");
        pc = 32'h40;
        bus.flush = 1'b0; bus.pc_addr = pc;
        tick("fr drain");
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_DEAD;
        tick("fr late ack");
        g_delay = 0; popped.delete();
        run_pops(1, 20, "fr refetch");
        if (popped.size() >= 1) chk("fr first pc", popped[0], 32'h40);

        // Flush with ack in the same cycle, queue full and then with an outstanding request
        do_reset("fa rst");
        g_ready = 1'b0; g_delay = 0;
        for (int i = 0; i < 20 && m_q_pc.size() < 2; i++) cyc("fa fill");
        chk("fa full", 32'(bus.pc_stall), 32'd1);
        bus.flush = 1'b1; bus.imem_ack = 1'b1;
        tick("fa flush full");
        chk("fa valid0", 32'(bus.if_valid), 32'd0);
        bus.flush = 1'b0; bus.imem_ack = 1'b0;
        #1;
        chk("fa stall0", 32'(bus.pc_stall), 32'd0);
        tick("fa after");
        g_delay = 1000;
        for (int i = 0; i < 10 && !(bus.imem_req && m_q_pc.size() == 1); i++) cyc("fa req");
        bus.flush = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
        tick("fa flush ack");
        bus.flush = 1'b0; bus.imem_ack = 1'b0;
        #1;
        chk("fa idle stall0", 32'(bus.pc_stall), 32'd0);
        tick("fa idle");

        // Reset mid-request, then a clean fetch at 0x0
        do_reset("rm rst");
        g_delay = 1000; g_ready = 1'b1;
        run_until_req(5, "rm wait");
        rst = 1'b0;
        tick("rm reset");
        chk("rm req0", 32'(bus.imem_req), 32'd0);
        rst = 1'b1; pc = 32'd0; age = 0; g_delay = 0; popped.delete();
        run_pops(1, 20, "rm refetch");
        if (popped.size() >= 1) chk("rm first pc", popped[0], 32'h0);

        // Random traffic
        g_rand = 1'b1;
        for (int i = 0; i < 3000; i++) cyc("rnd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch stage directly downstream of the program counter.
- Takes the current fetch address from the PC and issues one request at a time to instruction memory over a req/ack handshake.
- Buffers returned instructions with their PC in a 2-entry queue and presents them to decode with valid/ready.
- Back-pressures the PC via pc_stall; discards stale work on a taken jump (flush).

Parameters:
- WORD_WIDTH, 32, width of addresses and instruction words (matches `WORD_WIDTH).
- FIFO_DEPTH, 2, output queue entries; fixed at 2, other values unsupported.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low (asserted when 0).
- pc_addr  in  WORD_WIDTH  fetch address from the PC (its current address).
- pc_valid  in  1  pc_addr is valid this cycle.
- pc_stall  out  1  PC must hold; address not accepted this cycle.
- flush  in  1  taken jump; drop queued and in-flight instructions.
- imem_req  out  1  instruction memory request.
- imem_addr  out  WORD_WIDTH  request address.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  WORD_WIDTH  instruction word, valid with imem_ack.
- if_valid  out  1  if_inst/if_pc valid to decode.
- if_inst  out  WORD_WIDTH  head-of-queue instruction.
- if_pc  out  WORD_WIDTH  address of if_inst.
- id_ready  in  1  decode consumes head when if_valid is also 1.

Behaviour:
- Reset (rst==0 at clk edge): state IDLE, queue empty, imem_req=0, imem_addr=0, if_valid=0, if_inst=0, if_pc=0.
- pc_stall is combinational. It equals 0 exactly when: rst is released, state is IDLE, flush is 0, and queue count after this cycle's pop is below 2.
- FSM IDLE:
  - Accepts an address when pc_valid=1 and pc_stall=0.
  - Registers imem_addr=pc_addr and sets imem_req=1 in the next cycle.
  - Goes to REQ.
- FSM REQ:
  - imem_req and imem_addr are held stable until imem_ack.
  - imem_ack is sampled only while imem_req=1; ack is legal in the first REQ cycle.
  - On ack: push {imem_rdata, imem_addr}, drop imem_req, go to IDLE.
- FSM DRAIN:
  - Entered from REQ on flush without ack in the same cycle.
  - imem_req stays high until ack.
  - On ack: discard data, drop imem_req, go to IDLE. No push.
- Only one outstanding request at a time. A new address can be accepted in the same cycle the ack returns to IDLE only on the following cycle; there is no same-cycle reissue.
- Latency: address accepted in cycle T, imem_req high T+1. With ack at T+1, if_valid=1 at T+2.
- Queue:
  - Count is 0..2.
  - Push and pop in the same cycle are allowed, including when full.
  - Outputs are registered head; no combinational path from imem_rdata to if_inst.
  - With if_valid=1 and id_ready=0, if_inst/if_pc hold stable.
- Flush (highest priority):
  - Empties the queue; if_valid=0 next cycle.
  - An ack arriving in the flush cycle is discarded and the FSM goes to IDLE.
  - REQ without ack goes to DRAIN.
  - IDLE stays IDLE.
  - No address is accepted during the flush cycle (pc_stall=1).
- Flush while already in DRAIN: no effect beyond clearing the queue.
- Reset mid-request: imem_req dropped immediately at the reset edge. The memory must tolerate an abandoned request.
- Addresses pass through unmodified. No alignment checks; the PC owns the +4 arithmetic.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_wait_cnt [31:0] and perf_flush_cnt [31:0].
  - perf_wait_cnt increments each cycle imem_req=1 and imem_ack=0.
  - perf_flush_cnt increments each cycle flush=1 and either the queue is non-empty or a request is outstanding.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and counters absent; the rest of the behaviour is identical.

Test Plan:
- Zero-wait fetch: after reset, pc_valid=1, pc_addr 0,4,8, ack the cycle after each req, id_ready=1 -> if_pc 0,4,8 with matching if_inst. First if_valid 2 cycles after first accept; pc_stall=1 on the cycles in REQ.
- Back-pressure: id_ready=0, fetch 0x0, 0x4, 0x8 -> queue holds 0x0 and 0x4, pc_stall=1 while holding 0x8. Raise id_ready -> 0x0, 0x4, 0x8 in order, none lost or duplicated.
- Slow memory: ack delayed 3 cycles -> imem_req/imem_addr stable all 3 cycles; with FETCH_PERF_EN, perf_wait_cnt=3.
- Flush in REQ: flush at addr 0x10, ack 2 cycles later with data 0xDEAD -> 0xDEAD never on if_inst. Next accept is 0x40 from the PC after the jump; if_pc=0x40.
- Flush with ack same cycle, queue holding 2 entries -> if_valid=0 next cycle, acked data dropped, FSM IDLE, pc_stall=0 the following cycle.
- Reset mid-REQ: rst=0 for one cycle while imem_req=1 -> imem_req=0, if_valid=0, if_inst/if_pc=0 after the edge. A clean fetch at 0x0 follows release.
